// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and exception codes
// used by both CP0 and the control unit.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IM_LSB     = 10;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IE_BIT     = 0;
    localparam int CAUSE_BD_BIT  = 31;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int INT_LINES     = 6;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId register file plus the exception/interrupt
// request logic, evaluated on the instruction sitting in M.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h2024_1029,
    parameter int          EXC_CODE_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            A1,
    input  logic [4:0]            A2,
    input  logic [31:0]           Din,
    input  logic                  En,
    input  logic [31:0]           VPC,
    input  logic                  BDIn,
    input  logic [EXC_CODE_W-1:0] ExcCodeIn,
    input  logic [5:0]            HWInt,
    input  logic                  EXLClr,
    output logic                  Req,
    output logic [31:0]           EPCOut,
    output logic [31:0]           Dout
);

    logic [INT_LINES-1:0]  sr_im;
    logic                  sr_exl;
    logic                  sr_ie;
    logic                  cause_bd;
    logic [INT_LINES-1:0]  cause_ip;
    logic [EXC_CODE_W-1:0] cause_exc;
    logic [31:0]           epc;

    logic int_req;
    logic exc_req;

    // Interrupts look at the live lines, not the latched IP copy.
    assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (ExcCodeIn != '0) & ~sr_exl;
    assign Req     = int_req | exc_req;
    assign EPCOut  = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                // The victim does not commit, so its mtc0 and eret are dropped.
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? EXC_CODE_W'(EXC_INT) : ExcCodeIn;
                cause_bd  <= BDIn;
                epc       <= BDIn ? (VPC - 32'd4) : VPC;
            end else begin
                if (En && A2 == REG_SR) begin
                    sr_im  <= Din[SR_IM_LSB +: INT_LINES];
                    sr_exl <= Din[SR_EXL_BIT];
                    sr_ie  <= Din[SR_IE_BIT];
                end
                if (En && A2 == REG_EPC) begin
                    epc <= Din;
                end
                // Placed after the SR write so eret's EXL clear has the last word.
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (A1)
            REG_SR: begin
                Dout[SR_IM_LSB +: INT_LINES] = sr_im;
                Dout[SR_EXL_BIT]             = sr_exl;
                Dout[SR_IE_BIT]              = sr_ie;
            end
            REG_CAUSE: begin
                Dout[CAUSE_BD_BIT]                  = cause_bd;
                Dout[CAUSE_IP_LSB +: INT_LINES]     = cause_ip;
                Dout[CAUSE_EXC_LSB +: EXC_CODE_W]   = cause_exc;
            end
            REG_EPC:  Dout = epc;
            REG_PRID: Dout = PRID;
            default:  Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a word-level model.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2;
    logic [31:0] din, vpc;
    logic        en, bd_in, exl_clr;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out, dout;

    int tests_run    = 0;
    int tests_failed = 0;

    cp0_unit dut (
        .clk      (clk),
        .reset    (reset),
        .A1       (a1),
        .A2       (a2),
        .Din      (din),
        .En       (en),
        .VPC      (vpc),
        .BDIn     (bd_in),
        .ExcCodeIn(exc_code),
        .HWInt    (hw_int),
        .EXLClr   (exl_clr),
        .Req      (req),
        .EPCOut   (epc_out),
        .Dout     (dout)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model (whole 32-bit register words) ----------------
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;
    localparam logic [31:0] PRID_V  = 32'h2024_1029;

    logic [31:0] m_sr, m_cause, m_epc;
    bit          model_valid = 0;

    function automatic bit m_int_req();
        return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit m_exc_req();
        return (exc_code != 5'd0) && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        case (r)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit ir, er;
        ir = m_int_req();
        er = m_exc_req();
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
            model_valid = 1;
        end else if (ir || er) begin
            m_sr    = m_sr | 32'h2;
            m_cause = {bd_in, 15'd0, hw_int, 3'd0, (ir ? 5'd0 : exc_code), 2'd0};
            m_epc   = vpc - (bd_in ? 32'd4 : 32'd0);
        end else begin
            m_cause[15:10] = hw_int;
            if (en && a2 == 5'd12) m_sr = din & SR_MASK;
            if (en && a2 == 5'd14) m_epc = din;
            if (exl_clr) m_sr[1] = 1'b0;
        end
    end

    // ---------------- scoreboard: {req, epc, dout} ----------------
    logic [64:0] exp_q[$];

    always @(negedge clk) begin
        logic [64:0] e;
        if (model_valid) begin
            exp_q.push_back({(m_int_req() || m_exc_req()), m_epc, m_read(a1)});
            e = exp_q.pop_front();
            tests_run++;
            if (req !== e[64]) begin
                tests_failed++;
                $display("FAIL req t=%0t got=%b exp=%b", $time, req, e[64]);
            end
            tests_run++;
            if (epc_out !== e[63:32]) begin
                tests_failed++;
                $display("FAIL epc_out t=%0t got=%h exp=%h", $time, epc_out, e[63:32]);
            end
            tests_run++;
            if (dout !== e[31:0]) begin
                tests_failed++;
                $display("FAIL dout a1=%0d t=%0t got=%h exp=%h", a1, $time, dout, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; en = 0; a2 = 0; din = 0; vpc = 0; bd_in = 0;
        exc_code = 0; exl_clr = 0; a1 = 0;
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic read_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
        a1 = r;
        #1;
        check_lit(name, dout, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        hw_int = 0;
        reset  = 1;
        tick(); tick();
        reset = 0;

        // reset state
        read_reg("reset_sr", 5'd12, 32'h0);
        read_reg("reset_cause", 5'd13, 32'h0);
        read_reg("reset_epc", 5'd14, 32'h0);
        tick();
        read_reg("reset_prid", 5'd15, 32'h2024_1029);
        check_lit("reset_req", {31'd0, req}, 32'd0);
        tick();

        // interrupt
        en = 1; a2 = 5'd12; din = 32'h0000_FC01;
        tick();
        en = 0; hw_int = 6'b000100;
        #1 check_lit("int_req", {31'd0, req}, 32'd1);
        tick();
        read_reg("int_cause", 5'd13, 32'h0000_1000);
        read_reg("int_sr", 5'd12, 32'h0000_FC03);
        check_lit("int_masked", {31'd0, req}, 32'd0);
        tick();

        // exception in delay slot
        hw_int = 0; exl_clr = 1;
        tick();
        exl_clr = 0; exc_code = 5'd12; vpc = 32'h0000_3010; bd_in = 1;
        #1 check_lit("ov_req", {31'd0, req}, 32'd1);
        tick();
        exc_code = 0; bd_in = 0;
        read_reg("ov_epc", 5'd14, 32'h0000_300C);
        read_reg("ov_cause", 5'd13, 32'h8000_0030);
        tick();

        // mtc0 EPC suppressed by a concurrent exception
        exl_clr = 1;
        tick();
        exl_clr = 0; en = 1; a2 = 5'd14; din = 32'h1234; exc_code = 5'd10; vpc = 32'h0000_4000;
        tick();
        en = 0; exc_code = 0;
        read_reg("ri_epc", 5'd14, 32'h0000_4000);
        read_reg("ri_cause", 5'd13, 32'h0000_0028);

        // masking while EXL=1, then eret
        exc_code = 5'd4;
        #1 check_lit("exl_mask_req", {31'd0, req}, 32'd0);
        tick();
        read_reg("exl_mask_cause", 5'd13, 32'h0000_0028);
        exc_code = 0; exl_clr = 1;
        tick();
        exl_clr = 0;
        read_reg("eret_sr", 5'd12, 32'h0000_FC01);
        exc_code = 5'd4;
        #1 check_lit("adel_req", {31'd0, req}, 32'd1);
        tick();

        // interrupt beats syscall, EPC wraps
        exc_code = 0; exl_clr = 1;
        tick();
        exl_clr = 0; hw_int = 6'b000001; exc_code = 5'd8; vpc = 32'h0; bd_in = 1;
        tick();
        exc_code = 0; bd_in = 0;
        read_reg("prio_cause", 5'd13, 32'h8000_0400);
        read_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        tick();

        // reset wins over a pending request
        exl_clr = 1;
        tick();
        exl_clr = 0;
        #1 check_lit("pre_reset_req", {31'd0, req}, 32'd1);
        reset = 1;
        tick();
        reset = 0; hw_int = 0;
        read_reg("rst_sr", 5'd12, 32'h0);
        read_reg("rst_cause", 5'd13, 32'h0);
        read_reg("rst_epc", 5'd14, 32'h0);
        tick();

        // randomized traffic, checked by the scoreboard each cycle
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            a1       = 5'($urandom_range(10, 17));
            en       = ($urandom_range(0, 9) < 3);
            a2       = 5'($urandom_range(11, 16));
            din      = $urandom();
            vpc      = {$urandom_range(0, 3) == 0 ? 30'd0 : 30'($urandom()), 2'b00};
            bd_in    = 1'($urandom_range(0, 1));
            exl_clr  = ($urandom_range(0, 4) == 0);
            hw_int   = ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'd0;
            case ($urandom_range(0, 11))
                0:       exc_code = 5'd4;
                1:       exc_code = 5'd5;
                2:       exc_code = 5'd8;
                3:       exc_code = 5'd10;
                4:       exc_code = 5'd12;
                5:       exc_code = 5'($urandom());
                default: exc_code = 5'd0;
            endcase
            tick();
        end

        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
